// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the ex_muldiv HI/LO unit: op codes, FSM states,
// iteration count and conditional two's-complement helpers.
package ex_muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_MFHI  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MFLO  = 3'd5;
    localparam logic [2:0] MULDIV_OP_MTHI  = 3'd6;
    localparam logic [2:0] MULDIV_OP_MTLO  = 3'd7;

    localparam logic [1:0] MULDIV_ST_IDLE = 2'd0;
    localparam logic [1:0] MULDIV_ST_RUN  = 2'd1;
    localparam logic [1:0] MULDIV_ST_FIX  = 2'd2;

    localparam int MULDIV_ITER = 32;

    function automatic logic [31:0] neg32_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64_if(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the ex_muldiv HI/LO unit.
interface ex_muldiv_if;

    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] rsValue;
    logic [31:0] rtValue;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    modport master (
        output start, op, flush, rsValue, rtValue,
        input  busy, stall, done, hi, lo, result
    );

    modport slave (
        input  start, op, flush, rsValue, rtValue,
        output busy, stall, done, hi, lo, result
    );

endinterface

// File: rtl/ex_divider.sv
// Restoring shift-subtract divider datapath on unsigned magnitudes; one
// quotient bit per step. Only instantiated when MULDIV_DIV_EN is defined.
module ex_divider
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [32:0] partial;
    logic [31:0] diff;
    logic        fits;

    // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
    always_comb begin
        partial = {rem_q, quo_q[31]};
        fits    = partial >= {1'b0, dvsr_q};
        diff    = partial[31:0] - dvsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        if (load) begin
            rem_d  = 32'd0;
            quo_d  = dividend;
            dvsr_d = divisor;
        end else if (step) begin
            rem_d = fits ? diff : partial[31:0];
            quo_d = {quo_q[30:0], fits};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            dvsr_q <= 32'd0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage: FSM, sign handling,
// shift-add multiplier and HI/LO. Define MULDIV_DIV_EN to include the divider.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q, prod_d;
    logic        sign_res_q, sign_res_d;

    logic        op_signed, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;

`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        sign_rem_q, sign_rem_d;
    logic        div0_q, div0_d;
    logic        div_load, div_step;
    logic [31:0] quotient, remainder;

    ex_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quotient),
        .remainder (remainder)
    );
`endif

    always_comb begin
        op_signed = (bus.op == MULDIV_OP_MULT) || (bus.op == MULDIV_OP_DIV);
        sign_a    = op_signed & bus.rsValue[31];
        sign_b    = op_signed & bus.rtValue[31];
        mag_a     = neg32_if(sign_a, bus.rsValue);
        mag_b     = neg32_if(sign_b, bus.rtValue);
        mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        sign_res_d = sign_res_q;
`ifdef MULDIV_DIV_EN
        is_div_d   = is_div_q;
        sign_rem_d = sign_rem_q;
        div0_d     = div0_q;
        div_load   = 1'b0;
        div_step   = 1'b0;
`endif
        case (state_q)
            MULDIV_ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        MULDIV_OP_MULT, MULDIV_OP_MULTU: begin
                            state_d    = MULDIV_ST_RUN;
                            cnt_d      = 6'd0;
                            mcand_d    = mag_a;
                            prod_d     = {32'd0, mag_b};
                            sign_res_d = sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
                            is_div_d   = 1'b0;
`endif
                        end
                        MULDIV_OP_DIV, MULDIV_OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                            state_d    = MULDIV_ST_RUN;
                            cnt_d      = 6'd0;
                            is_div_d   = 1'b1;
                            sign_res_d = sign_a ^ sign_b;
                            sign_rem_d = sign_a;
                            div0_d     = (bus.rtValue == 32'd0);
                            div_load   = 1'b1;
`else
                            done_d     = 1'b1;
`endif
                        end
                        MULDIV_OP_MTHI: hi_d = bus.rsValue;
                        MULDIV_OP_MTLO: lo_d = bus.rsValue;
                        default: ;
                    endcase
                end
            end
            MULDIV_ST_RUN: begin
                if (bus.flush) begin
                    state_d = MULDIV_ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(MULDIV_ITER - 1)) state_d = MULDIV_ST_FIX;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) div_step = 1'b1;
                    else          prod_d   = {mul_sum, prod_q[31:1]};
`else
                    prod_d = {mul_sum, prod_q[31:1]};
`endif
                end
            end
            MULDIV_ST_FIX: begin
                state_d = MULDIV_ST_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        // Divide by zero keeps an all-ones quotient regardless of sign.
                        lo_d = div0_q ? 32'hFFFF_FFFF : neg32_if(sign_res_q, quotient);
                        hi_d = neg32_if(sign_rem_q, remainder);
                    end else begin
                        {hi_d, lo_d} = neg64_if(sign_res_q, prod_q);
                    end
`else
                    {hi_d, lo_d} = neg64_if(sign_res_q, prod_q);
`endif
                end
            end
            default: state_d = MULDIV_ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= MULDIV_ST_IDLE;
            cnt_q      <= 6'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            mcand_q    <= 32'd0;
            prod_q     <= 64'd0;
            sign_res_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            sign_res_q <= sign_res_d;
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div_q   <= 1'b0;
            sign_rem_q <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            is_div_q   <= is_div_d;
            sign_rem_q <= sign_rem_d;
            div0_q     <= div0_d;
        end
    end
`endif

    assign bus.busy   = (state_q != MULDIV_ST_IDLE);
    assign bus.stall  = bus.start & bus.busy;
    assign bus.done   = done_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.result = (bus.op == MULDIV_OP_MFHI) ? hi_q :
                        (bus.op == MULDIV_OP_MFLO) ? lo_q : 32'd0;

endmodule
